// File: rtl/regfile_write_arbiter_pkg.sv
// Shared defaults and requester ids for the register-file write arbiter.
package regfile_write_arbiter_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 5;
  localparam int unsigned CNT_W_DEF  = 16;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_DBG = 1'b1;

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Requester handshakes plus register-file write port of the write arbiter.
interface regfile_write_arbiter_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned CNT_W  = 16
);

  logic              hold;
  logic              req0_valid;
  logic [ADDR_W-1:0] req0_reg;
  logic [DATA_W-1:0] req0_data;
  logic              req0_ready;
  logic              req1_valid;
  logic [ADDR_W-1:0] req1_reg;
  logic [DATA_W-1:0] req1_data;
  logic              req1_ready;
  logic [ADDR_W-1:0] WriteReg;
  logic [DATA_W-1:0] WriteData;
  logic              RegWrite;
  logic [CNT_W-1:0]  wr_count;
  logic              last_grant;

  // Requester / register-file side.
  modport master (
    output hold, req0_valid, req0_reg, req0_data, req1_valid, req1_reg, req1_data,
    input  req0_ready, req1_ready, WriteReg, WriteData, RegWrite, wr_count, last_grant
  );

  // Arbiter side.
  modport slave (
    input  hold, req0_valid, req0_reg, req0_data, req1_valid, req1_reg, req1_data,
    output req0_ready, req1_ready, WriteReg, WriteData, RegWrite, wr_count, last_grant
  );

endinterface

// File: rtl/regfile_write_arbiter_rr_arbiter2.sv
// Two-way round-robin grant: the requester that did not win last gets a tie.
module rr_arbiter2
  import regfile_write_arbiter_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       hold,
  input  logic       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = '0;
    if (!hold) begin
      unique case (valid)
        2'b01: grant[REQ_CPU] = 1'b1;
        2'b10: grant[REQ_DBG] = 1'b1;
        2'b11: begin
          if (last_grant == REQ_CPU) grant[REQ_DBG] = 1'b1;
          else                       grant[REQ_CPU] = 1'b1;
        end
        default: grant = '0;
      endcase
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Arbitrates two register-file writers onto one write port with a one-cycle
// registered output stage and a saturating committed-write counter.
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input logic                    clk,
  input logic                    startin,
  regfile_write_arbiter_if.slave bus
);

  logic [1:0]        valid;
  logic [1:0]        grant;
  logic [1:0]        ready;
  logic              handshake;
  logic [ADDR_W-1:0] sel_reg;
  logic [DATA_W-1:0] sel_data;

  logic [ADDR_W-1:0] write_reg_d, write_reg_q;
  logic [DATA_W-1:0] write_data_d, write_data_q;
  logic              reg_write_d, reg_write_q;
  logic [CNT_W-1:0]  wr_count_d, wr_count_q;
  logic              last_grant_d, last_grant_q;

  assign valid = {bus.req1_valid, bus.req0_valid};

  rr_arbiter2 u_rr_arbiter2 (
    .valid      (valid),
    .hold       (bus.hold),
    .last_grant (last_grant_q),
    .grant      (grant)
  );

  // Grants are masked while reset is held so nothing is accepted during reset.
  assign ready          = startin ? 2'b00 : grant;
  assign bus.req0_ready = ready[REQ_CPU];
  assign bus.req1_ready = ready[REQ_DBG];
  assign handshake      = |ready;

  assign sel_reg  = ready[REQ_DBG] ? bus.req1_reg  : bus.req0_reg;
  assign sel_data = ready[REQ_DBG] ? bus.req1_data : bus.req0_data;

  always_comb begin
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;
    reg_write_d  = 1'b0;
    wr_count_d   = wr_count_q;
    last_grant_d = last_grant_q;
    if (handshake) begin
      write_reg_d  = sel_reg;
      write_data_d = sel_data;
      last_grant_d = ready[REQ_DBG] ? REQ_DBG : REQ_CPU;
      // r0 is hardwired: the handshake completes but nothing is committed.
      if (sel_reg != '0) begin
        reg_write_d = 1'b1;
        if (wr_count_q != '1) wr_count_d = wr_count_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge startin) begin
    if (startin) begin
      write_reg_q  <= '0;
      write_data_q <= '0;
      reg_write_q  <= 1'b0;
      wr_count_q   <= '0;
      last_grant_q <= REQ_DBG;
    end else begin
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
      reg_write_q  <= reg_write_d;
      wr_count_q   <= wr_count_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign bus.WriteReg   = write_reg_q;
  assign bus.WriteData  = write_data_q;
  assign bus.RegWrite   = reg_write_q;
  assign bus.wr_count   = wr_count_q;
  assign bus.last_grant = last_grant_q;

endmodule
